// File: rtl/branch_update_queue_if.sv
// rtl/branch_update_queue_if.sv - prediction, resolve, update and statistics signals of the branch update queue
interface branch_update_queue_if #(
    parameter int IDX_W = 11
);
    logic             pred_val;
    logic             pred_rdy;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             resolve_val;
    logic             resolve_rdy;
    logic             resolve_taken;
    logic             flush;
    logic             update_en;
    logic             update_val;
    logic [IDX_W-1:0] update_idx;
    logic             mispredict;
    logic [15:0]      num_updates;
    logic [15:0]      num_mispred;

    modport master (
        output pred_val, pred_idx, pred_taken, resolve_val, resolve_taken, flush,
        input  pred_rdy, resolve_rdy, update_en, update_val, update_idx, mispredict,
        input  num_updates, num_mispred
    );

    modport slave (
        input  pred_val, pred_idx, pred_taken, resolve_val, resolve_taken, flush,
        output pred_rdy, resolve_rdy, update_en, update_val, update_idx, mispredict,
        output num_updates, num_mispred
    );
endinterface

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-flight branch FIFO feeding registered PHT updates on resolve
module branch_update_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_update_queue_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic             tkn_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             update_en_q, update_en_d;
    logic             update_val_q, update_val_d;
    logic [IDX_W-1:0] update_idx_q, update_idx_d;
    logic             mispredict_q, mispredict_d;
    logic [15:0]      num_updates_q, num_updates_d;
    logic [15:0]      num_mispred_q, num_mispred_d;

    logic             pred_rdy;
    logic             resolve_rdy;
    logic             resolve_fire;
    logic             head_taken;
    logic [IDX_W-1:0] head_idx;
    logic             mis;
    logic             clear;
    logic             enq;

    // Ready flags come only from registered occupancy; a resolve never frees a slot for the same edge.
    assign pred_rdy     = (count_q != FULL);
    assign resolve_rdy  = (count_q != '0);
    assign resolve_fire = bus.resolve_val && resolve_rdy;
    assign head_idx     = idx_mem[head_q];
    assign head_taken   = tkn_mem[head_q];
    assign mis          = resolve_fire && (head_taken != bus.resolve_taken);
    // A mispredict makes every younger entry wrong-path, so it squashes like a flush.
    assign clear        = bus.flush || mis;
    assign enq          = bus.pred_val && pred_rdy && !clear;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        update_en_d   = resolve_fire;
        mispredict_d  = mis;
        update_val_d  = update_val_q;
        update_idx_d  = update_idx_q;
        num_updates_d = num_updates_q;
        num_mispred_d = num_mispred_q;

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (resolve_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({enq, resolve_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (resolve_fire) begin
            update_val_d = bus.resolve_taken;
            update_idx_d = head_idx;
        end

        // Counters step at the resolve edge so they move together with the update strobe.
        if (resolve_fire && (num_updates_q != 16'hFFFF)) begin
            num_updates_d = num_updates_q + 16'd1;
        end
        if (mis && (num_mispred_q != 16'hFFFF)) begin
            num_mispred_d = num_mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            update_en_q   <= 1'b0;
            update_val_q  <= 1'b0;
            update_idx_q  <= '0;
            mispredict_q  <= 1'b0;
            num_updates_q <= '0;
            num_mispred_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            update_en_q   <= update_en_d;
            update_val_q  <= update_val_d;
            update_idx_q  <= update_idx_d;
            mispredict_q  <= mispredict_d;
            num_updates_q <= num_updates_d;
            num_mispred_q <= num_mispred_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            idx_mem[tail_q] <= bus.pred_idx;
            tkn_mem[tail_q] <= bus.pred_taken;
        end
    end

    assign bus.pred_rdy    = pred_rdy;
    assign bus.resolve_rdy = resolve_rdy;
    assign bus.update_en   = update_en_q;
    assign bus.update_val  = update_val_q;
    assign bus.update_idx  = update_idx_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.num_updates = num_updates_q;
    assign bus.num_mispred = num_mispred_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - directed stimulus with a scoreboard of expected update strobes
module tb_branch_update_queue;
    logic clk;
    logic reset;

    branch_update_queue_if #(.IDX_W(11)) bus ();

    branch_update_queue #(.DEPTH(4), .IDX_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] idx;
        logic        val;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [10:0] idx, input logic val, input logic mis);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.mis = mis;
        exp_q.push_back(e);
    endtask

    // Inputs are held for exactly one rising edge, then released at edge+1.
    task automatic cycle(input logic pv, input logic [10:0] pi, input logic pt,
                         input logic rv, input logic rt, input logic fl);
        bus.pred_val      = pv;
        bus.pred_idx      = pi;
        bus.pred_taken    = pt;
        bus.resolve_val   = rv;
        bus.resolve_taken = rt;
        bus.flush         = fl;
        @(posedge clk);
        #1;
        bus.pred_val      = 1'b0;
        bus.resolve_val   = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic enq(input logic [10:0] pi, input logic pt);
        cycle(1'b1, pi, pt, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic rt);
        cycle(1'b0, 11'h0, 1'b0, 1'b1, rt, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus.update_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_update: got idx 0x%0h val %0d, required no update",
                             bus.update_idx, bus.update_val);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("upd_idx", 32'(bus.update_idx), 32'(e.idx));
                    chk("upd_val", 32'(bus.update_val), 32'(e.val));
                    chk("upd_mis", 32'(bus.mispredict), 32'(e.mis));
                end
            end else if (bus.mispredict) begin
                tests++;
                fails++;
                $display("FAIL mis_without_upd: got mispredict 1, required 0");
            end
        end
    end

    initial begin
        reset             = 1'b0;
        bus.pred_val      = 1'b0;
        bus.pred_idx      = '0;
        bus.pred_taken    = 1'b0;
        bus.resolve_val   = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_rdy", 32'(bus.pred_rdy), 32'd1);
        chk("rst_resolve_rdy", 32'(bus.resolve_rdy), 32'd0);
        chk("rst_update_en", 32'(bus.update_en), 32'd0);
        chk("rst_update_idx", 32'(bus.update_idx), 32'd0);
        chk("rst_num_updates", 32'(bus.num_updates), 32'd0);
        chk("rst_num_mispred", 32'(bus.num_mispred), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic correct prediction
        enq(11'h123, 1'b1);
        expect_upd(11'h123, 1'b1, 1'b0);
        res(1'b1);
        chk("basic_update_en", 32'(bus.update_en), 32'd1);
        chk("basic_num_updates", 32'(bus.num_updates), 32'd1);
        cycle(1'b0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_update_en", 32'(bus.update_en), 32'd0);
        chk("idle_hold_idx", 32'(bus.update_idx), 32'h123);
        chk("idle_hold_val", 32'(bus.update_val), 32'd1);

        // Fill to DEPTH, overflow attempt, drain in order
        enq(11'h010, 1'b1);
        enq(11'h020, 1'b0);
        enq(11'h030, 1'b1);
        enq(11'h040, 1'b0);
        chk("full_pred_rdy", 32'(bus.pred_rdy), 32'd0);
        chk("full_resolve_rdy", 32'(bus.resolve_rdy), 32'd1);
        enq(11'h050, 1'b1);
        expect_upd(11'h010, 1'b1, 1'b0);
        res(1'b1);
        expect_upd(11'h020, 1'b0, 1'b0);
        res(1'b0);
        expect_upd(11'h030, 1'b1, 1'b0);
        res(1'b1);
        expect_upd(11'h040, 1'b0, 1'b0);
        res(1'b0);
        chk("drained_resolve_rdy", 32'(bus.resolve_rdy), 32'd0);
        chk("drained_pred_rdy", 32'(bus.pred_rdy), 32'd1);
        chk("drained_num_updates", 32'(bus.num_updates), 32'd5);
        res(1'b1);

        // Mispredict squashes younger entries and a same-cycle enqueue
        enq(11'h0A1, 1'b0);
        enq(11'h0B2, 1'b1);
        enq(11'h0C3, 1'b1);
        expect_upd(11'h0A1, 1'b1, 1'b1);
        cycle(1'b1, 11'h0D4, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mis_resolve_rdy", 32'(bus.resolve_rdy), 32'd0);
        chk("mis_num_mispred", 32'(bus.num_mispred), 32'd1);
        chk("mis_num_updates", 32'(bus.num_updates), 32'd6);
        res(1'b1);
        res(1'b0);

        // Steady state at count 2 with pointer wrap
        enq(11'h101, 1'b1);
        enq(11'h102, 1'b0);
        for (int k = 0; k < 9; k++) begin
            expect_upd(11'h101 + 11'(k), 1'((k + 1) & 1), 1'b0);
            cycle(1'b1, 11'h103 + 11'(k), 1'((k + 3) & 1), 1'b1, 1'((k + 1) & 1), 1'b0);
        end
        chk("wrap_pred_rdy", 32'(bus.pred_rdy), 32'd1);
        chk("wrap_resolve_rdy", 32'(bus.resolve_rdy), 32'd1);
        expect_upd(11'h10A, 1'b0, 1'b0);
        res(1'b0);
        expect_upd(11'h10B, 1'b1, 1'b0);
        res(1'b1);
        chk("wrap_empty", 32'(bus.resolve_rdy), 32'd0);
        chk("wrap_num_updates", 32'(bus.num_updates), 32'd17);

        // Flush with simultaneous resolve and enqueue
        enq(11'h201, 1'b1);
        enq(11'h202, 1'b0);
        expect_upd(11'h201, 1'b1, 1'b0);
        cycle(1'b1, 11'h203, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_resolve_rdy", 32'(bus.resolve_rdy), 32'd0);
        chk("flush_pred_rdy", 32'(bus.pred_rdy), 32'd1);
        enq(11'h204, 1'b0);
        expect_upd(11'h204, 1'b0, 1'b0);
        res(1'b0);
        chk("flush_num_updates", 32'(bus.num_updates), 32'd19);
        chk("flush_num_mispred", 32'(bus.num_mispred), 32'd1);

        // Asynchronous reset mid-cycle with entries queued and strobe high
        enq(11'h301, 1'b1);
        enq(11'h302, 1'b1);
        enq(11'h303, 1'b1);
        enq(11'h304, 1'b1);
        res(1'b1);
        chk("pre_rst_update_en", 32'(bus.update_en), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_update_en", 32'(bus.update_en), 32'd0);
        chk("arst_update_val", 32'(bus.update_val), 32'd0);
        chk("arst_update_idx", 32'(bus.update_idx), 32'd0);
        chk("arst_mispredict", 32'(bus.mispredict), 32'd0);
        chk("arst_num_updates", 32'(bus.num_updates), 32'd0);
        chk("arst_num_mispred", 32'(bus.num_mispred), 32'd0);
        chk("arst_pred_rdy", 32'(bus.pred_rdy), 32'd1);
        chk("arst_resolve_rdy", 32'(bus.resolve_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        enq(11'h401, 1'b0);
        chk("post_rst_resolve_rdy", 32'(bus.resolve_rdy), 32'd1);
        expect_upd(11'h401, 1'b1, 1'b1);
        res(1'b1);
        chk("post_rst_num_updates", 32'(bus.num_updates), 32'd1);
        chk("post_rst_num_mispred", 32'(bus.num_mispred), 32'd1);
        chk("post_rst_empty", 32'(bus.resolve_rdy), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight branch entries; power of 2, minimum 2.
REQ-002 SHALL have parameter IDX_W, default 11, PHT index width (2048-entry PHT).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port pred_val  input  1  fetch stage presents a predicted branch.
REQ-006 SHALL have port pred_rdy  output  1  queue can accept a branch.
REQ-007 SHALL have port pred_idx  input  IDX_W  PHT index (PC xor GHR) used for the prediction.
REQ-008 SHALL have port pred_taken  input  1  predicted direction.
REQ-009 SHALL have port resolve_val  input  1  execute stage resolves the oldest branch.
REQ-010 SHALL have port resolve_rdy  output  1  queue holds at least one entry.
REQ-011 SHALL have port resolve_taken  input  1  actual direction.
REQ-012 SHALL have port flush  input  1  squash all queued entries.
REQ-013 SHALL have port update_en  output  1  one-cycle update strobe to the global predictor control.
REQ-014 SHALL have port update_val  output  1  actual direction for the update.
REQ-015 SHALL have port update_idx  output  IDX_W  PHT entry to update.
REQ-016 SHALL have port mispredict  output  1  accompanies update_en; predicted != actual.
REQ-017 SHALL have ports num_updates and num_mispred  output  16  statistics counters.

Function
REQ-018 SHALL store entries {pred_idx, pred_taken} in a circular buffer, enqueue at tail and dequeue at head, both pointers wrapping modulo DEPTH.
REQ-019 SHALL track occupancy with a counter of width log2(DEPTH)+1, range 0..DEPTH.
REQ-020 SHALL drive pred_rdy = (count != DEPTH) and resolve_rdy = (count != 0), combinationally from registered state only, with no bypass from resolve into enqueue.
REQ-021 SHALL enqueue on a clock edge with pred_val && pred_rdy, and dequeue the head on an edge with resolve_val && resolve_rdy (resolve fire).
REQ-022 SHALL leave count unchanged on a simultaneous enqueue and non-mispredicting resolve fire.
REQ-023 SHALL, one cycle after a resolve fire, assert update_en=1, update_val=resolve_taken, update_idx=head pred_idx, and mispredict=(head pred_taken != resolve_taken), as registered outputs.
REQ-024 SHALL hold update_en=0 and mispredict=0 in every cycle not following a resolve fire, with update_val and update_idx holding their last values.
REQ-025 SHALL, on a mispredicting resolve fire, clear the queue at that edge (count=0, head=tail), since all younger entries are wrong-path.
REQ-026 SHALL discard any enqueue in the same cycle as a mispredicting resolve fire or an asserted flush.
REQ-027 SHALL, on flush, clear the queue at that edge; a resolve fire in the same cycle still produces its update per REQ-023.
REQ-028 SHALL ignore resolve_val when resolve_rdy=0: no update and no state change.
REQ-029 SHALL increment num_updates on every update_en cycle and num_mispred on every mispredict cycle, saturating at 16'hFFFF.

Reset
REQ-030 SHALL, while reset=0, immediately force count=0, head=tail=0, update_en=0, update_val=0, update_idx=0, mispredict=0, num_updates=0, num_mispred=0; hence pred_rdy=1 and resolve_rdy=0.
REQ-031 SHALL, on reset assertion mid-operation, discard all queued entries and any pending update strobe; the first enqueue is accepted on the first rising edge with reset=1.

Verification
REQ-032 SHALL cover: reset, enqueue idx 0x123 with taken=1, resolve taken=1 -> next cycle update_en=1, update_val=1, update_idx=0x123, mispredict=0, num_updates=1.
REQ-033 SHALL cover: enqueue 4 entries (DEPTH=4) -> pred_rdy=0; fifth pred_val is ignored; resolve all 4 correctly -> updates in FIFO order, then resolve_rdy=0.
REQ-034 SHALL cover: enqueue A(taken=0), B, C; resolve A taken=1 -> update_idx=A, mispredict=1, count=0, num_mispred=1; later resolve_val produces no update.
REQ-035 SHALL cover: count=2 with simultaneous enqueue and correct resolve -> count stays 2; pointer wrap after 9 such cycles keeps FIFO order intact.
REQ-036 SHALL cover: flush with a simultaneous resolve and enqueue -> the update for the resolved head is emitted, the enqueue is dropped, and count=0.
REQ-037 SHALL cover: reset=0 asserted asynchronously mid-cycle with 3 entries and update_en=1 -> all outputs zero before the next edge, with pred_rdy=1.
